// File: rtl/control_unit.sv
// Multicycle FSM controller for the MIPS subset datapath (add/sub/and/addi/lw/sw/beq/bne/j).
// Outputs are registered from the next-state decode; only pc_write in BRANCH looks at eq directly.
module control_unit #(
  parameter int ADDR_PC_OFFSET = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       eq,
  output logic       pc_write,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       mdr_write,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state,
  output logic       ovf_err,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0, S_FETCH = 4'd1, S_FETCH_WAIT = 4'd2, S_DECODE = 4'd3,
    S_EXEC_R = 4'd4, S_EXEC_I = 4'd5, S_WB_R = 4'd6, S_WB_I = 4'd7,
    S_MEM_ADDR = 4'd8, S_MEM_READ = 4'd9, S_MEM_READ_WAIT = 4'd10, S_MEM_WB = 4'd11,
    S_MEM_WRITE = 4'd12, S_BRANCH = 4'd13, S_JUMP = 4'd14, S_HALT = 4'd15
  } state_t;

  state_t     state_q, state_d;
  logic       ovf_err_q, ovf_err_d, illegal_q, illegal_d;
  logic       pc_write_q, pc_write_d, mem_write_q, mem_write_d, ir_write_q, ir_write_d;
  logic       reg_write_q, reg_write_d, ab_write_q, ab_write_d;
  logic       alu_out_write_q, alu_out_write_d, mdr_write_q, mdr_write_d;
  logic       iord_q, iord_d, alu_src_a_q, alu_src_a_d, reg_dst_q, reg_dst_d;
  logic       mem_to_reg_q, mem_to_reg_d;
  logic [1:0] alu_src_b_q, alu_src_b_d, pc_source_q, pc_source_d;
  logic [2:0] alu_control_q, alu_control_d;
  logic       funct_ok, funct_arith, branch_taken;

  assign funct_ok     = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24);
  assign funct_arith  = (funct == 6'h20) || (funct == 6'h22);
  assign branch_taken = ((opcode == 6'h04) && eq) || ((opcode == 6'h05) && !eq);

  always_comb begin
    state_d   = state_q;
    ovf_err_d = ovf_err_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RESET:      state_d = S_FETCH;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:        state_d = funct_ok ? S_EXEC_R : S_HALT;
          6'h08:        state_d = S_EXEC_I;
          6'h23, 6'h2B: state_d = S_MEM_ADDR;
          6'h04, 6'h05: state_d = S_BRANCH;
          6'h02:        state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
        if (state_d == S_HALT) illegal_d = 1'b1;
      end
      S_EXEC_R: begin
        if (overflow && funct_arith) begin
          state_d   = S_HALT;
          ovf_err_d = 1'b1;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EXEC_I: begin
        if (overflow) begin
          state_d   = S_HALT;
          ovf_err_d = 1'b1;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_MEM_ADDR:      state_d = (opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:      state_d = S_MEM_READ_WAIT;
      S_MEM_READ_WAIT: state_d = S_MEM_WB;
      S_HALT:          state_d = S_HALT;
      default:         state_d = S_FETCH;
    endcase
  end

  // Decode the state being entered so the registered outputs line up with state_q.
  always_comb begin
    pc_write_d = 1'b0; mem_write_d = 1'b0; ir_write_d = 1'b0; reg_write_d = 1'b0;
    ab_write_d = 1'b0; alu_out_write_d = 1'b0; mdr_write_d = 1'b0; iord_d = 1'b0;
    alu_src_a_d = 1'b0; alu_src_b_d = 2'b00; alu_control_d = 3'b000; pc_source_d = 2'b00;
    reg_dst_d = 1'b0; mem_to_reg_d = 1'b0;
    case (state_d)
      S_FETCH_WAIT: begin
        ir_write_d = 1'b1; pc_write_d = 1'b1; alu_src_b_d = 2'b01; alu_control_d = 3'b001;
      end
      S_DECODE: begin
        ab_write_d = 1'b1; alu_out_write_d = 1'b1; alu_src_b_d = 2'b11; alu_control_d = 3'b001;
      end
      S_EXEC_R: begin
        alu_src_a_d = 1'b1; alu_out_write_d = 1'b1;
        alu_control_d = (funct == 6'h20) ? 3'b001 : (funct == 6'h22) ? 3'b010 : 3'b011;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a_d = 1'b1; alu_src_b_d = 2'b10; alu_control_d = 3'b001; alu_out_write_d = 1'b1;
      end
      S_WB_R:          begin reg_write_d = 1'b1; reg_dst_d = 1'b1; end
      S_WB_I:          reg_write_d = 1'b1;
      S_MEM_READ:      iord_d = 1'b1;
      S_MEM_READ_WAIT: begin iord_d = 1'b1; mdr_write_d = 1'b1; end
      S_MEM_WB:        begin reg_write_d = 1'b1; mem_to_reg_d = 1'b1; end
      S_MEM_WRITE:     begin iord_d = 1'b1; mem_write_d = 1'b1; end
      S_BRANCH: begin
        alu_src_a_d = 1'b1; alu_control_d = 3'b111; pc_source_d = 2'b01;
      end
      S_JUMP:          begin pc_source_d = 2'b10; pc_write_d = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET; ovf_err_q <= 1'b0; illegal_q <= 1'b0;
      pc_write_q <= 1'b0; mem_write_q <= 1'b0; ir_write_q <= 1'b0; reg_write_q <= 1'b0;
      ab_write_q <= 1'b0; alu_out_write_q <= 1'b0; mdr_write_q <= 1'b0; iord_q <= 1'b0;
      alu_src_a_q <= 1'b0; alu_src_b_q <= 2'b00; alu_control_q <= 3'b000;
      pc_source_q <= 2'b00; reg_dst_q <= 1'b0; mem_to_reg_q <= 1'b0;
    end else begin
      state_q <= state_d; ovf_err_q <= ovf_err_d; illegal_q <= illegal_d;
      pc_write_q <= pc_write_d; mem_write_q <= mem_write_d; ir_write_q <= ir_write_d;
      reg_write_q <= reg_write_d; ab_write_q <= ab_write_d;
      alu_out_write_q <= alu_out_write_d; mdr_write_q <= mdr_write_d; iord_q <= iord_d;
      alu_src_a_q <= alu_src_a_d; alu_src_b_q <= alu_src_b_d; alu_control_q <= alu_control_d;
      pc_source_q <= pc_source_d; reg_dst_q <= reg_dst_d; mem_to_reg_q <= mem_to_reg_d;
    end
  end

  assign pc_write      = pc_write_q | ((state_q == S_BRANCH) & branch_taken);
  assign mem_write     = mem_write_q;
  assign ir_write      = ir_write_q;
  assign reg_write     = reg_write_q;
  assign ab_write      = ab_write_q;
  assign alu_out_write = alu_out_write_q;
  assign mdr_write     = mdr_write_q;
  assign iord          = iord_q;
  assign alu_src_a     = alu_src_a_q;
  assign alu_src_b     = alu_src_b_q;
  assign alu_control   = alu_control_q;
  assign pc_source     = pc_source_q;
  assign reg_dst       = reg_dst_q;
  assign mem_to_reg    = mem_to_reg_q;
  assign state         = state_q;
  assign ovf_err       = ovf_err_q;
  assign illegal       = illegal_q;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle FSM controller that drives every control strobe and mux select of the CPU datapath (PC, memory, instruction register, register bank, A/B, ALU, ALUOut, MDR).
- Consumes the opcode and funct fields decoded by the instruction register and the ALU flags, and sequences fetch, decode, execute, memory and writeback.
- Covers the MIPS subset add, sub, and, addi, lw, sw, beq, bne and j.
- Illegal encodings and arithmetic overflow halt the core with sticky status flags.

Parameters:
- ADDR_PC_OFFSET, 4, constant selected on alu_src_b=01 (documentation only; the datapath owns the constant)

Ports:
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; forces RESET state
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0] (low bits of the immediate field)
- overflow  in  1  ALU arithmetic overflow (combinational)
- eq  in  1  ALU A==B flag (combinational)
- pc_write  out  1  PC load enable
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_write  out  1  register bank write
- ab_write  out  1  A/B register load
- alu_out_write  out  1  ALUOut register load
- mdr_write  out  1  memory data register load
- iord  out  1  memory address: 0=PC, 1=ALUOut
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
- alu_control  out  3  000 pass A, 001 add, 010 sub, 011 and, 111 compare
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target {PC[31:28],IR[25:0],2'b00}
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- state  out  4  current state code, for debug
- ovf_err  out  1  sticky: halted on overflow
- illegal  out  1  sticky: halted on unsupported opcode/funct

Behaviour:
- Reset (asynchronous, active-high): state=RESET(0).
  - All strobes and selects are 0; ovf_err and illegal are cleared.
  - Reset asserted mid-instruction aborts it immediately, with no partial write after the reset edge.
- Outputs are Moore-decoded from the state register. The only exception is pc_write in BRANCH, which is Mealy on eq.
- Any strobe not listed for a state is 0. Any select not listed is 0.
- Memory reads have one cycle of latency, so every read spends one extra state holding the address.
- State sequence (code, name: asserted signals -> next state):
  - 0 RESET: none -> FETCH.
  - 1 FETCH: iord=0 -> FETCH_WAIT.
  - 2 FETCH_WAIT: iord=0, ir_write, pc_write, alu_src_a=0, alu_src_b=01, alu_control=001, pc_source=00 -> DECODE.
  - 3 DECODE: ab_write, alu_out_write, alu_src_a=0, alu_src_b=11, alu_control=001 (precomputes the branch target). Next state by opcode:
    - 0x00 -> EXEC_R if funct ∈ {0x20,0x22,0x24}, else HALT with illegal.
    - 0x08 -> EXEC_I.
    - 0x23 or 0x2B -> MEM_ADDR.
    - 0x04 or 0x05 -> BRANCH.
    - 0x02 -> JUMP.
    - other -> HALT with illegal=1.
  - 4 EXEC_R: alu_src_a=1, alu_src_b=00, alu_control = 001 (add) / 010 (sub) / 011 (and), alu_out_write.
    - If overflow and funct is add or sub -> HALT with ovf_err=1 (ALUOut is not consumed).
    - Otherwise -> WB_R.
  - 5 EXEC_I: alu_src_a=1, alu_src_b=10, alu_control=001, alu_out_write -> HALT(ovf_err) if overflow, else WB_I.
  - 6 WB_R: reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
  - 7 WB_I: reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
  - 8 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_control=001, alu_out_write -> MEM_READ if lw, MEM_WRITE if sw. Overflow is ignored here.
  - 9 MEM_READ: iord=1 -> MEM_READ_WAIT.
  - 10 MEM_READ_WAIT: iord=1, mdr_write -> MEM_WB.
  - 11 MEM_WB: reg_write, reg_dst=0, mem_to_reg=1 -> FETCH.
  - 12 MEM_WRITE: iord=1, mem_write -> FETCH.
  - 13 BRANCH: alu_src_a=1, alu_src_b=00, alu_control=111, pc_source=01. pc_write = (opcode==0x04 & eq) | (opcode==0x05 & !eq) -> FETCH.
  - 14 JUMP: pc_source=10, pc_write -> FETCH.
  - 15 HALT: all strobes 0; stays in HALT until reset. ovf_err and illegal hold their values.
- Latency in cycles, FETCH through last state:
  - R-type and addi: 5.
  - lw: 7.
  - sw: 5.
  - beq, bne, j: 4.
- At most one of reg_write and mem_write is asserted in any state.
- pc_write is never asserted outside FETCH_WAIT, BRANCH and JUMP.

Test Plan:
- reset high for 2 cycles, then release -> all outputs 0 while reset is high; state goes 0 -> 1 -> 2. Required in state 2: pc_write=1, ir_write=1, alu_src_b=01, alu_control=001.
- opcode=0x00, funct=0x20, overflow=0 -> state codes 1,2,3,4,6,1. In state 6: reg_write=1, reg_dst=1, mem_to_reg=0.
- opcode=0x23 (lw) -> state codes 1,2,3,8,9,10,11,1. mdr_write=1 only in state 10. iord=1 in 9 and 10. reg_write=1 with mem_to_reg=1 in 11.
- opcode=0x04 with eq=1 -> pc_write=1, pc_source=01 in state 13. Repeat with eq=0 -> pc_write=0. opcode=0x05 with eq=0 -> pc_write=1.
- opcode=0x08 with overflow=1 in EXEC_I -> state 15, ovf_err=1, reg_write never asserted. After that, HALT persists for 10 cycles regardless of inputs. Asserting reset clears ovf_err and returns to state 0.
- opcode=0x3F -> state 15 with illegal=1. Separately, reset asserted asynchronously during state 12 (sw) -> mem_write drops to 0 immediately, without waiting for a clock edge.
